// File: rtl/ctrl_pulse_gen_pkg.sv
// Shared definitions for the pushbutton pulse generator: debounce FSM encoding,
// counter width and the default debounce length.
package ctrl_pulse_gen_pkg;

    localparam int DB_CYCLES_DEF = 4;
    localparam int CNT_W         = 8;

    // Gray-style encoding so IDLE<->HELD paths only flip one bit per step.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_CONFIRM_HI = 2'b01,
        ST_HELD       = 2'b11,
        ST_CONFIRM_LO = 2'b10
    } state_t;

    // True when the channel has accepted a high level and has not yet confirmed release.
    function automatic logic is_pressed(input state_t s);
        return (s == ST_HELD) || (s == ST_CONFIRM_LO);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton channel: 2-flop synchronizer, saturating confirm counter and a
// 4-state debounce FSM whose CONFIRM_HI -> HELD step is the raw pulse condition.
module btn_debounce
    import ctrl_pulse_gen_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_btn,
    output state_t o_state,
    output logic   o_raw_pulse
);

    localparam logic [CNT_W-1:0] DB_N    = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = DB_N - 1'b1;

    logic [1:0]       r_sync;
    logic             w_level;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_level = r_sync[1];
    assign o_state = r_state;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_raw_pulse = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_level) begin
                    if (DB_N == 8'd1) begin
                        // Single-cycle debounce confirms on the first high sample.
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = DB_N;
                        o_raw_pulse = 1'b1;
                    end else begin
                        w_state_nxt = ST_CONFIRM_HI;
                        w_cnt_nxt   = 8'd1;
                    end
                end
            end
            ST_CONFIRM_HI: begin
                if (!w_level) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= DB_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = DB_N;
                    o_raw_pulse = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!w_level) begin
                    if (DB_N == 8'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = DB_N;
                    end else begin
                        w_state_nxt = ST_CONFIRM_LO;
                        w_cnt_nxt   = 8'd1;
                    end
                end
            end
            ST_CONFIRM_LO: begin
                if (w_level) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= DB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = DB_N;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pulse_gen.sv
// Debounces the set/clear pushbuttons and emits one registered pulse per press,
// with clear taking priority over set.
module ctrl_pulse_gen
    import ctrl_pulse_gen_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_set,
    input  logic btn_clr,
    output logic set_pulse,
    output logic clr_pulse,
    output logic busy
);

    state_t w_set_state;
    state_t w_clr_state;
    logic   w_set_raw;
    logic   w_clr_raw;
    logic   w_set_fire;
    logic   r_set_pulse;
    logic   r_clr_pulse;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
        .clk         (clk),
        .rst         (clr),
        .i_btn       (btn_set),
        .o_state     (w_set_state),
        .o_raw_pulse (w_set_raw)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
        .clk         (clk),
        .rst         (clr),
        .i_btn       (btn_clr),
        .o_state     (w_clr_state),
        .o_raw_pulse (w_clr_raw)
    );

    // A set press is discarded outright while clear fires or is still held.
    assign w_set_fire = w_set_raw && !w_clr_raw && !is_pressed(w_clr_state);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_set_pulse <= 1'b0;
            r_clr_pulse <= 1'b0;
        end else begin
            r_set_pulse <= w_set_fire;
            r_clr_pulse <= w_clr_raw;
        end
    end

    assign set_pulse = r_set_pulse;
    assign clr_pulse = r_clr_pulse;
    assign busy      = (w_set_state != ST_IDLE) || (w_clr_state != ST_IDLE);

endmodule

// File: tb/tb_ctrl_pulse_gen.sv
// Directed-vector bench for ctrl_pulse_gen (DB_CYCLES=4): per-cycle table of
// button levels and expected {set_pulse, clr_pulse, busy}, plus reset and bounce sequences.
module tb_ctrl_pulse_gen;

    typedef struct {
        string name;
        logic  s;
        logic  c;
        logic  es;
        logic  ec;
        logic  eb;
    } vec_t;

    logic clk;
    logic clr;
    logic btn_set;
    logic btn_clr;
    logic set_pulse;
    logic clr_pulse;
    logic busy;

    int   n_vec;
    int   n_err;
    vec_t tbl[$];

    ctrl_pulse_gen #(.DB_CYCLES(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .btn_set   (btn_set),
        .btn_clr   (btn_clr),
        .set_pulse (set_pulse),
        .clr_pulse (clr_pulse),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One rising edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        check("idle_timeout", {2'b00, busy}, 3'b000);
    endtask

    task automatic add_vec(input string name, input logic s, input logic c,
                           input logic es, input logic ec, input logic eb);
        vec_t v;
        v.name = name; v.s = s; v.c = c; v.es = es; v.ec = ec; v.eb = eb;
        tbl.push_back(v);
    endtask

    initial begin
        logic bs;
        logic bc;
        logic prev_s;
        logic prev_c;
        int   n_pulses;

        n_vec = 0;
        n_err = 0;

        // Row k drives the buttons before edge k of its phase and checks after edge k.
        for (int k = 1; k <= 28; k++)
            add_vec("hold", k <= 20, 1'b0, k == 6, 1'b0, k >= 3 && k <= 25);
        for (int k = 1; k <= 10; k++)
            add_vec("glitch", k <= 3, 1'b0, 1'b0, 1'b0, k >= 3 && k <= 5);
        for (int k = 1; k <= 18; k++)
            add_vec("both", k <= 10, k <= 10, 1'b0, k == 6, k >= 3 && k <= 15);
        for (int k = 1; k <= 48; k++)
            add_vec("clr_block", (k >= 8 && k <= 14) || (k >= 30 && k <= 40), k <= 20,
                    k == 35, k == 6, (k >= 3 && k <= 25) || (k >= 32 && k <= 45));

        clr     = 1'b1;
        btn_set = 1'b0;
        btn_clr = 1'b0;
        step();
        step();
        check("reset_state", {set_pulse, clr_pulse, busy}, 3'b000);
        clr = 1'b0;

        foreach (tbl[i]) begin
            btn_set = tbl[i].s;
            btn_clr = tbl[i].c;
            step();
            check(tbl[i].name, {set_pulse, clr_pulse, busy}, {tbl[i].es, tbl[i].ec, tbl[i].eb});
        end

        // Reset mid-count, then release with the button still held.
        wait_idle(20);
        btn_set = 1'b1;
        for (int k = 1; k <= 3; k++) step();
        check("pre_rst_busy", {set_pulse, clr_pulse, busy}, 3'b001);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("rst_async", {set_pulse, clr_pulse, busy}, 3'b000);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_hold", {set_pulse, clr_pulse, busy}, 3'b000);
        end
        @(negedge clk);
        clr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("rst_repress", {1'b0, set_pulse, clr_pulse}, {1'b0, k == 6, 1'b0});
        end
        btn_set = 1'b0;
        wait_idle(20);

        // Random bounce: outputs exclusive and every pulse exactly one cycle wide.
        bs       = 1'b0;
        bc       = 1'b0;
        prev_s   = 1'b0;
        prev_c   = 1'b0;
        n_pulses = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(7) == 0) bs = ~bs;
            if ($urandom_range(7) == 0) bc = ~bc;
            btn_set = bs;
            btn_clr = bc;
            step();
            check("rand_props", {set_pulse & clr_pulse, prev_s & set_pulse, prev_c & clr_pulse}, 3'b000);
            if (set_pulse || clr_pulse) n_pulses++;
            prev_s = set_pulse;
            prev_c = clr_pulse;
        end
        check("rand_activity", {2'b00, n_pulses > 0}, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_pulse_gen.md
CTRL_PULSE_GEN -- requirements
Module: ctrl_pulse_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4, is the number of consecutive clock edges a synchronized button level must hold before it is accepted; legal range 1..255.
REQ-002 Port clk, input, 1, the single system clock; all state changes on the rising edge.
REQ-003 Port clr, input, 1, the asynchronous active-high reset.
REQ-004 Port btn_set, input, 1, raw asynchronous set pushbutton, active-high.
REQ-005 Port btn_clr, input, 1, raw asynchronous clear pushbutton, active-high.
REQ-006 Port set_pulse, output, 1, one-cycle registered pulse driving the downstream counter's set input.
REQ-007 Port clr_pulse, output, 1, one-cycle registered pulse driving the downstream counter's clr input.
REQ-008 Port busy, output, 1, high while either channel is in a non-IDLE state.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer; the synchronized level is valid after the 2nd edge that samples the raw level.
REQ-010 Each channel SHALL run its own 4-state FSM:
- IDLE: accepted level is low.
- CONFIRM_HI: counting toward a high.
- HELD: accepted level is high.
- CONFIRM_LO: counting toward a low.
REQ-011 IDLE -> CONFIRM_HI when the synced level is high; the 8-bit counter loads 1.
REQ-012 In CONFIRM_HI:
- synced high -> counter increments;
- counter == DB_CYCLES -> HELD on that edge;
- synced low -> IDLE, counter cleared.
REQ-013 HELD -> CONFIRM_LO, then CONFIRM_LO -> IDLE, SHALL follow the mirror rules of REQ-011/REQ-012; a glitch during CONFIRM_LO returns the channel to HELD.
REQ-014 The raw pulse condition SHALL be the CONFIRM_HI -> HELD transition; the output pulse is registered and is high for exactly one cycle following that edge.
REQ-015 Latency: with DB_CYCLES=N and a clean press, the raw pulse condition occurs on edge N+2 after the first sampling edge, and the output is high between edges N+2 and N+3.
REQ-016 Release SHALL never generate a pulse; holding a button SHALL generate exactly one pulse.
REQ-017 If the clr channel's raw pulse condition and the set channel's raw pulse condition occur on the same edge, clr_pulse asserts and set_pulse is dropped, not deferred.
REQ-018 A set raw pulse condition occurring while the clr channel is in HELD or CONFIRM_LO SHALL be dropped (clear priority).
REQ-019 set_pulse and clr_pulse SHALL never be high in the same cycle.
REQ-020 The counter SHALL never wrap; it saturates at DB_CYCLES.
REQ-021 busy SHALL be combinational from the channel states.

Reset
REQ-022 clr high SHALL asynchronously force:
- synchronizers and counters to 0;
- both FSMs to IDLE;
- set_pulse and clr_pulse to 0.
REQ-023 A button held through reset release SHALL be treated as a new press and pulse after the REQ-015 latency.
REQ-024 Reset asserted mid-count SHALL discard the partial count with no pulse emitted.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=00, CONFIRM_HI=01, HELD=11, CONFIRM_LO=10) and the DB_CYCLES default.
REQ-026 One sub-module, btn_debounce (synchronizer, counter, FSM, raw pulse condition), SHALL be instantiated twice; the priority logic and output registers live in ctrl_pulse_gen.

Verification
REQ-027 DB_CYCLES=4, btn_set raised before edge 1 and held 20 cycles -> set_pulse high only between edges 6 and 7, one pulse total.
REQ-028 btn_set high for 3 cycles then low (glitch) -> no set_pulse; busy returns low within 6 cycles.
REQ-029 btn_set and btn_clr raised together and held -> clr_pulse once at edge 6, set_pulse never.
REQ-030 btn_clr held, then btn_set pressed -> no set_pulse; after btn_clr is released and debounced low, a fresh btn_set press -> set_pulse once.
REQ-031 clr asserted at edge 4 of a press, then released with btn_set still high -> no pulse before release; set_pulse 6 edges after release.
REQ-032 Random raw bounce on both buttons over 10k cycles -> set_pulse and clr_pulse never high together, and each pulse is exactly 1 cycle wide.
